// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM capture: measures high time and period in ticks, reports 8-bit duty
// Flags loss of signal when no edge is seen for TIMEOUT_TICKS ticks.
module pwm_capture #(
    parameter int CLK_DIV       = 196,
    parameter int CNT_W         = 16,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [7:0]       duty_out,
    output logic [CNT_W-1:0] period_out,
    output logic             duty_valid,
    output logic             signal_lost
);

    localparam int PW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [PW-1:0]    presc_q, presc_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             div_busy_q, div_busy_d;
    logic [2:0]       div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] div_rem_q, div_rem_d;
    logic [7:0]       div_quo_q, div_quo_d;
    logic [CNT_W-1:0] div_per_q, div_per_d;
    logic             div_force_q, div_force_d;
    logic [7:0]       duty_q, duty_d;
    logic [CNT_W-1:0] period_out_q, period_out_d;
    logic             valid_q, valid_d;
    logic             lost_q, lost_d;

    logic             tick, rise, fall, timeout;
    logic [CNT_W:0]   div_shift;
    logic             div_ge;
    logic [7:0]       div_quo_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
    endfunction

    always_comb begin
        sync1_d      = pwm_in;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        tick         = (presc_q == PW'(CLK_DIV - 1));
        presc_d      = tick ? '0 : presc_q + PW'(1);
        rise         = sync2_q & ~prev_q;
        fall         = ~sync2_q & prev_q;
        timeout      = (state_q != ST_IDLE) && (idle_cnt_q >= CNT_W'(TIMEOUT_TICKS));

        state_d      = state_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        div_busy_d   = div_busy_q;
        div_cnt_d    = div_cnt_q;
        div_rem_d    = div_rem_q;
        div_quo_d    = div_quo_q;
        div_per_d    = div_per_q;
        div_force_d  = div_force_q;
        duty_d       = duty_q;
        period_out_d = period_out_q;
        valid_d      = 1'b0;
        lost_d       = lost_q;

        if (rise || fall) begin
            idle_cnt_d = '0;
        end else if (tick) begin
            idle_cnt_d = sat_inc(idle_cnt_q);
        end else begin
            idle_cnt_d = idle_cnt_q;
        end

        // Restoring division: remainder stays below the divisor, so one extra bit suffices.
        div_shift    = {div_rem_q, 1'b0};
        div_ge       = (div_shift >= {1'b0, div_per_q});
        div_quo_next = {div_quo_q[6:0], div_ge};
        if (div_busy_q) begin
            div_rem_d = div_ge ? (div_shift[CNT_W-1:0] - div_per_q) : div_shift[CNT_W-1:0];
            div_quo_d = div_quo_next;
            div_cnt_d = div_cnt_q + 3'd1;
            if (div_cnt_q == 3'd7) begin
                div_busy_d   = 1'b0;
                duty_d       = div_force_q ? 8'd255 : div_quo_next;
                period_out_d = div_per_q;
                valid_d      = 1'b1;
                lost_d       = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d      = ST_HIGH;
                    high_cnt_d   = tick ? CNT_W'(1) : '0;
                    period_cnt_d = tick ? CNT_W'(1) : '0;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    period_cnt_d = sat_inc(period_cnt_q);
                end
                if (fall) begin
                    state_d = ST_LOW;
                end else if (tick) begin
                    high_cnt_d = sat_inc(high_cnt_q);
                end
            end
            ST_LOW: begin
                if (rise) begin
                    div_busy_d   = 1'b1;
                    div_cnt_d    = '0;
                    div_rem_d    = high_cnt_q;
                    div_quo_d    = '0;
                    div_per_d    = period_cnt_q;
                    div_force_d  = (high_cnt_q >= period_cnt_q) || (period_cnt_q == '0);
                    high_cnt_d   = tick ? CNT_W'(1) : '0;
                    period_cnt_d = tick ? CNT_W'(1) : '0;
                    state_d      = ST_HIGH;
                end else if (tick) begin
                    period_cnt_d = sat_inc(period_cnt_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loss of signal wins over both a same-cycle edge and a finishing divide.
        if (timeout) begin
            state_d      = ST_IDLE;
            div_busy_d   = 1'b0;
            duty_d       = (state_q == ST_LOW) ? 8'd0 : 8'd255;
            period_out_d = '0;
            valid_d      = 1'b1;
            lost_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            presc_q      <= '0;
            state_q      <= ST_IDLE;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            idle_cnt_q   <= '0;
            div_busy_q   <= 1'b0;
            div_cnt_q    <= '0;
            div_rem_q    <= '0;
            div_quo_q    <= '0;
            div_per_q    <= '0;
            div_force_q  <= 1'b0;
            duty_q       <= '0;
            period_out_q <= '0;
            valid_q      <= 1'b0;
            lost_q       <= 1'b1;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            presc_q      <= presc_d;
            state_q      <= state_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            div_busy_q   <= div_busy_d;
            div_cnt_q    <= div_cnt_d;
            div_rem_q    <= div_rem_d;
            div_quo_q    <= div_quo_d;
            div_per_q    <= div_per_d;
            div_force_q  <= div_force_d;
            duty_q       <= duty_d;
            period_out_q <= period_out_d;
            valid_q      <= valid_d;
            lost_q       <= lost_d;
        end
    end

    assign duty_out    = duty_q;
    assign period_out  = period_out_q;
    assign duty_valid  = valid_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture with CLK_DIV=10
module tb_pwm_capture;

    localparam int CLK_DIV = 10;
    localparam int CNT_W   = 16;
    localparam int TO      = 1024;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [7:0]       duty_out;
    logic [CNT_W-1:0] period_out;
    logic             duty_valid;
    logic             signal_lost;

    pwm_capture #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W), .TIMEOUT_TICKS(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .period_out (period_out),
        .duty_valid (duty_valid),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    // cyc equals the prescaler phase: ticks fall in cycles where cyc % 10 == 9.
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int duty;
        int per;
        int lost;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_exp(input int d, input int p, input int l, input int c);
        exp_t e;
        e.duty = d;
        e.per  = p;
        e.lost = l;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && duty_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_duty_valid_pending", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("duty_out", int'(duty_out), mon_e.duty);
                check("period_out", int'(period_out), mon_e.per);
                check("signal_lost", int'(signal_lost), mon_e.lost);
                if (mon_e.cyc >= 0) check("valid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic seg(input int ticks);
        wait_cyc(ticks * CLK_DIV);
    endtask

    // Rise driven in cycle c is detected in c+2; the result appears in c+11.
    task automatic drive_rise(input bit push, input int d, input int p);
        pwm_in = 1'b1;
        if (push) push_exp(d, p, 0, cyc + 11);
    endtask

    int fh[7] = '{64, 64, 64, 128, 255, 1, 200};
    int fp[7] = '{256, 256, 256, 256, 256, 258, 300};
    int fd[7] = '{64, 64, 64, 128, 255, 0, 170};
    int c0;

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        wait_cyc(3);
        check("reset_duty", int'(duty_out), 0);
        check("reset_period", int'(period_out), 0);
        check("reset_valid", int'(duty_valid), 0);
        check("reset_lost", int'(signal_lost), 1);
        rst = 1'b0;
        wait_cyc(7);

        for (int i = 0; i < 7; i++) begin
            if (i == 0) drive_rise(1'b0, 0, 0);
            else        drive_rise(1'b1, fd[i-1], fp[i-1]);
            seg(fh[i]);
            if (i == 0) check("lost_before_first_result", int'(signal_lost), 1);
            pwm_in = 1'b0;
            seg(fp[i] - fh[i]);
        end
        drive_rise(1'b1, fd[6], fp[6]);
        seg(50);
        pwm_in = 1'b0;
        push_exp(0, 0, 1, -1);
        seg(TO + 16);
        check("lost_after_low_timeout", int'(signal_lost), 1);

        drive_rise(1'b0, 0, 0);
        seg(90);
        pwm_in = 1'b0;
        seg(90);
        drive_rise(1'b1, 128, 180);
        push_exp(255, 0, 1, -1);
        seg(1100);
        pwm_in = 1'b0;
        seg(20);
        drive_rise(1'b0, 0, 0);
        seg(64);
        pwm_in = 1'b0;
        seg(192);
        drive_rise(1'b1, 64, 256);
        seg(128);
        pwm_in = 1'b0;
        seg(128);
        drive_rise(1'b1, 128, 256);
        seg(10);
        pwm_in = 1'b0;
        seg(30);
        drive_rise(1'b0, 0, 0);
        wait_cyc(4);
        rst    = 1'b1;
        pwm_in = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(20);
        check("post_rst_duty", int'(duty_out), 0);
        check("post_rst_period", int'(period_out), 0);
        check("post_rst_lost", int'(signal_lost), 1);
        check("post_rst_valid", int'(duty_valid), 0);

        while ((cyc % CLK_DIV) != 0) @(negedge clk);
        c0 = cyc;
        pwm_in = 1'b1;
        wait_cyc(1);
        pwm_in = 1'b0;
        wait_cyc(3);
        push_exp(255, 0, 0, c0 + 15);
        pwm_in = 1'b1;
        wait_cyc(1);
        pwm_in = 1'b0;
        wait_cyc(30);
        check("glitch_lost", int'(signal_lost), 0);
        check("pending_expectations", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
